// File: rtl/jtcop_objbuf_pkg.sv
// Shared constants and FSM encoding for the double-buffered object line buffer.
package jtcop_objbuf_pkg;

  localparam int OBJBUF_AW = 9;
  localparam int OBJBUF_DW = 8;

  // Colour index 0 means "no object here"
  localparam logic [3:0] TRANSP_IDX = 4'd0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } objbuf_state_e;

endpackage

// File: rtl/jtcop_objbuf_ram.sv
// One line-buffer bank: port 0 is write-only (draw/clear), port 1 reads and erases.
module jtframe_dual_ram
  import jtcop_objbuf_pkg::*;
#(
  parameter int AW = OBJBUF_AW,
  parameter int DW = OBJBUF_DW
) (
  input  logic          clk,
  input  logic [DW-1:0] data0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  input  logic [DW-1:0] data1,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: storage arrays carry no reset; the owner sweeps them clean after reset instead.
  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= data0;
    if (we1) mem[addr1] <= data1;
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtcop_objbuf.sv
// Object line buffer: draw into one bank while the other is scanned out and erased.
module jtcop_objbuf
  import jtcop_objbuf_pkg::*;
#(
  parameter int AW = OBJBUF_AW,
  parameter int DW = OBJBUF_DW
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          flip,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  input  logic          buf_we,
  output logic          line_start,
  output logic          clr_busy,
  output logic [DW-1:0] obj_pxl
);

  objbuf_state_e state;
  logic          bank;
  logic          lhbl_l;
  logic          swap;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] erase_addr;
  logic          erase_pend;
  logic          erase_bank;
  logic [DW-1:0] scan_data;

  logic [AW-1:0] addr0;
  logic [DW-1:0] data0;
  logic [1:0]    we0;
  logic [AW-1:0] addr1;
  logic [1:0]    we1;
  logic [DW-1:0] q1 [2];

  assign swap    = lhbl_l & ~LHBL;
  assign rd_addr = flip ? {rd_cnt[AW-1:8], ~rd_cnt[7:0]} : rd_cnt;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    addr0 = buf_addr;
    data0 = buf_data;
    we0   = 2'b00;
    addr1 = rd_addr;
    we1   = 2'b00;
    if (state == CLEAR) begin
      addr0 = clr_cnt;
      data0 = '0;
      we0   = 2'b11;
    end else if (buf_we && buf_data[3:0] != TRANSP_IDX) begin
      we0 = bank ? 2'b10 : 2'b01;
    end
    // The erase reuses the scan port in the clk after the read
    if (erase_pend) begin
      addr1 = erase_addr;
      we1   = erase_bank ? 2'b10 : 2'b01;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_bank
    jtframe_dual_ram #(.AW(AW), .DW(DW)) u_ram (
      .clk   (clk),
      .data0 (data0),
      .addr0 (addr0),
      .we0   (we0[i]),
      .data1 ('0),
      .addr1 (addr1),
      .we1   (we1[i]),
      .q1    (q1[i])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      bank       <= 1'b0;
      lhbl_l     <= 1'b0;
      line_start <= 1'b0;
      clr_busy   <= 1'b1;
      rd_cnt     <= '0;
      erase_pend <= 1'b0;
      erase_addr <= '0;
      erase_bank <= 1'b0;
      scan_data  <= '0;
      obj_pxl    <= '0;
    end else begin
      lhbl_l <= LHBL;
      if (swap) bank <= ~bank;

      case (state)
        CLEAR: begin
          clr_cnt    <= clr_cnt + 1'b1;
          line_start <= 1'b0;
          if (&clr_cnt) begin
            state      <= RUN;
            clr_busy   <= 1'b0;
            line_start <= 1'b1;
          end
        end
        RUN: line_start <= swap;
        default: state <= CLEAR;
      endcase

      erase_pend <= pxl_cen & LHBL;
      if (pxl_cen && LHBL) begin
        erase_addr <= rd_addr;
        erase_bank <= ~bank;
      end

      if (!LHBL) rd_cnt <= '0;
      else if (pxl_cen) rd_cnt <= rd_cnt + 1'b1;

      // Hold the read result until the next pixel strobe picks it up
      if (!LHBL || state == CLEAR) scan_data <= '0;
      else if (erase_pend) scan_data <= q1[erase_bank];

      if (pxl_cen) obj_pxl <= (LHBL && state == RUN) ? scan_data : '0;
    end
  end

endmodule
